dot_product_engine_param: RTL and testbench

Parametrised streaming dot-product engine; next generation of the fixed 8-bit DP datapath behind axi_system_top.
- Generalised in operand width, vector length and accumulator width.
- Adds signed/unsigned mode, valid/ready operand and result handshakes, and a sticky overflow flag.
- Sits behind the AXI slave register block: control registers drive start, vec_len and mode; DP_RESULT is read back through the slave.

---
 rtl/dot_product_engine_param.sv | 124 ++++++++++++
 tb/tb_dot_product_engine_param.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/dot_product_engine_param.sv
// Streaming dot-product engine: accumulates in_a*in_b over vec_len handshaked beats.
// Optional DP_SATURATE_EN clamps the accumulator on overflow instead of wrapping.
module dot_product_engine_param #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 8,
  parameter int ACC_W  = 32
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              start,
  input  logic [LEN_W-1:0]  vec_len,
  input  logic              signed_mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] DP_A,
  output logic [DATA_W-1:0] DP_B,
  output logic [ACC_W-1:0]  DP_RESULT,
  output logic              overflow,
  output logic              busy
);

  // state | meaning
  // IDLE  | waiting for start; result of last operation held
  // ACCUM | accepting operand pairs
  // DONE  | result presented until res_ready
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                     state, state_nxt;
  logic [LEN_W-1:0]           len_q, cnt, cnt_inc;
  logic                       mode_q;
  logic                       beat, last_beat, start_ok;
  logic signed [2*DATA_W-1:0] prod_s;
  logic [2*DATA_W-1:0]        prod_u;
  logic [ACC_W-1:0]           prod_ext, acc_nxt;
  logic [ACC_W:0]             sum;
  logic                       add_ovf;

  assign start_ok  = (state == IDLE) && start;
  assign beat      = in_valid && (state == ACCUM);
  assign cnt_inc   = cnt + 1'b1;
  assign last_beat = (cnt_inc == len_q);

  assign prod_s   = $signed(in_a) * $signed(in_b);
  assign prod_u   = in_a * in_b;
  assign prod_ext = mode_q ? ACC_W'(prod_s) : ACC_W'(prod_u);
  assign sum      = {1'b0, DP_RESULT} + {1'b0, prod_ext};

  // Signed overflow: both addends share a sign that the result does not.
  assign add_ovf = mode_q
    ? ((DP_RESULT[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != DP_RESULT[ACC_W-1]))
    : sum[ACC_W];

`ifdef DP_SATURATE_EN
  // Once clamped, the accumulator is frozen for the rest of the operation.
  always_comb begin
    acc_nxt = sum[ACC_W-1:0];
    if (overflow) begin
      acc_nxt = DP_RESULT;
    end else if (add_ovf) begin
      if (!mode_q)
        acc_nxt = '1;
      else if (DP_RESULT[ACC_W-1])
        acc_nxt = {1'b1, {(ACC_W-1){1'b0}}};
      else
        acc_nxt = {1'b0, {(ACC_W-1){1'b1}}};
    end
  end
`else
  assign acc_nxt = sum[ACC_W-1:0];
`endif

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    res_valid = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE:    if (start) state_nxt = (vec_len == '0) ? DONE : ACCUM;
      ACCUM: begin
        in_ready = 1'b1;
        if (beat && last_beat) state_nxt = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      len_q     <= '0;
      mode_q    <= 1'b0;
      cnt       <= '0;
      DP_A      <= '0;
      DP_B      <= '0;
      DP_RESULT <= '0;
      overflow  <= 1'b0;
    end else if (start_ok) begin
      len_q     <= vec_len;
      mode_q    <= signed_mode;
      cnt       <= '0;
      DP_RESULT <= '0;
      overflow  <= 1'b0;
    end else if (beat) begin
      DP_A      <= in_a;
      DP_B      <= in_b;
      cnt       <= cnt_inc;
      DP_RESULT <= acc_nxt;
      if (add_ovf) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dot_product_engine_param.sv
// Directed bench for dot_product_engine_param with a result scoreboard.
// A second instance with ACC_W=16 exercises accumulator overflow.
module tb_dot_product_engine_param;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  vec_len = '0;
  logic        signed_mode = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_a = '0, in_b = '0;
  logic        res_ready = 1'b0;

  logic        in_ready, res_valid, overflow, busy;
  logic [7:0]  DP_A, DP_B;
  logic [31:0] DP_RESULT;

  logic        in_ready1, res_valid1, overflow1, busy1;
  logic [7:0]  dp_a1, dp_b1;
  logic [15:0] dp_result1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] res;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        ovf;
  } exp_t;
  exp_t sb[$];

  always #5 ACLK = ~ACLK;

  dot_product_engine_param #(.DATA_W(8), .LEN_W(8), .ACC_W(32)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .start(start), .vec_len(vec_len),
    .signed_mode(signed_mode), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .res_valid(res_valid), .res_ready(res_ready),
    .DP_A(DP_A), .DP_B(DP_B), .DP_RESULT(DP_RESULT), .overflow(overflow), .busy(busy)
  );

  dot_product_engine_param #(.DATA_W(8), .LEN_W(8), .ACC_W(16)) dut16 (
    .ACLK(ACLK), .ARESET(ARESET), .start(start), .vec_len(vec_len),
    .signed_mode(signed_mode), .in_valid(in_valid), .in_ready(in_ready1),
    .in_a(in_a), .in_b(in_b), .res_valid(res_valid1), .res_ready(res_ready),
    .DP_A(dp_a1), .DP_B(dp_b1), .DP_RESULT(dp_result1), .overflow(overflow1), .busy(busy1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] res, input logic [7:0] a, input logic [7:0] b,
                      input logic ovf);
    exp_t e;
    e.res = res; e.a = a; e.b = b; e.ovf = ovf;
    sb.push_back(e);
  endtask

  task automatic do_start(input logic [7:0] len, input logic mode);
    start = 1'b1; vec_len = len; signed_mode = mode;
    @(negedge ACLK);
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b);
    logic ok;
    in_a = a; in_b = b; in_valid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      ok = in_ready;
      @(negedge ACLK);
      if (ok) return;
    end
    check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic collect(input logic with_start);
    exp_t e;
    in_valid = 1'b0;
    for (int n = 0; n < 50 && !res_valid; n++) @(negedge ACLK);
    check("res_valid_wait", 32'(res_valid), 32'd1);
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    check("dp_result", DP_RESULT, e.res);
    check("dp_a", 32'(DP_A), 32'(e.a));
    check("dp_b", 32'(DP_B), 32'(e.b));
    check("overflow", 32'(overflow), 32'(e.ovf));
    res_ready = 1'b1;
    if (with_start) begin start = 1'b1; vec_len = 8'd5; end
    @(negedge ACLK);
    res_ready = 1'b0; start = 1'b0;
    check("res_valid_drop", 32'(res_valid), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
    if (with_start) begin
      @(negedge ACLK);
      check("start_dropped_in_done", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    // Reset values
    #12;
    check("rst_result", DP_RESULT, 32'd0);
    check("rst_flags", {27'd0, in_ready, res_valid, overflow, busy, 1'b0}, 32'd0);
    check("rst_dp_ab", {16'd0, DP_A, DP_B}, 32'd0);
    @(negedge ACLK);
    ARESET = 1'b0;
    @(negedge ACLK);

    // Unsigned, in_valid held; result one cycle after the third beat
    push(32'd44, 8'd5, 8'd6, 1'b0);
    do_start(8'd3, 1'b0);
    send(8'd1, 8'd2);
    send(8'd3, 8'd4);
    check("no_early_valid", 32'(res_valid), 32'd0);
    send(8'd5, 8'd6);
    check("valid_latency", 32'(res_valid), 32'd1);
    check("in_ready_done", 32'(in_ready), 32'd0);
    collect(1'b0);

    // Signed then unsigned on the same data
    push(32'hFFFF_FF7E, 8'h80, 8'h01, 1'b0);
    do_start(8'd2, 1'b1);
    send(8'hFF, 8'h02);
    send(8'h80, 8'h01);
    collect(1'b0);
    push(32'd255 * 32'd2 + 32'd128, 8'h80, 8'h01, 1'b0);
    do_start(8'd2, 1'b0);
    send(8'hFF, 8'h02);
    send(8'h80, 8'h01);
    collect(1'b0);

    // Backpressure on both sides, start ignored in DONE, start+res_ready together
    push(32'd140, 8'd8, 8'd9, 1'b0);
    do_start(8'd4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      send(8'(2 + 2 * i), 8'(3 + 2 * i));
      in_valid = 1'b0; in_a = 8'hAA; in_b = 8'h55;
      @(negedge ACLK);
    end
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin start = 1'b1; vec_len = 8'd1; end
      @(negedge ACLK);
      start = 1'b0;
      check("hold_valid", 32'(res_valid), 32'd1);
      check("hold_result", DP_RESULT, 32'd140);
    end
    collect(1'b1);

    // Zero-length operation
    push(32'd0, 8'd8, 8'd9, 1'b0);
    do_start(8'd0, 1'b0);
    check("zero_len_valid", 32'(res_valid), 32'd1);
    check("zero_len_no_ready", 32'(in_ready), 32'd0);
    collect(1'b0);

    // Overflow: wraps past 32 bits on neither instance, past 16 bits on dut16
    push(32'h0001_FC02, 8'd255, 8'd255, 1'b0);
    do_start(8'd2, 1'b0);
    send(8'd255, 8'd255);
    send(8'd255, 8'd255);
`ifdef DP_SATURATE_EN
    check("ovf16_result", 32'(dp_result1), 32'h0000_FFFF);
`else
    check("ovf16_result", 32'(dp_result1), 32'h0000_FC02);
`endif
    check("ovf16_flag", 32'(overflow1), 32'd1);
    collect(1'b0);

    // Reset in the middle of an operation
    do_start(8'd4, 1'b0);
    send(8'd1, 8'd1);
    send(8'd2, 8'd2);
    in_valid = 1'b0;
    check("partial_tracking", DP_RESULT, 32'd5);
    ARESET = 1'b1;
    #1;
    check("midrst_result", DP_RESULT, 32'd0);
    check("midrst_flags", {27'd0, in_ready, res_valid, overflow, busy, 1'b0}, 32'd0);
    check("midrst_dp_ab", {16'd0, DP_A, DP_B}, 32'd0);
    @(negedge ACLK);
    ARESET = 1'b0;
    @(negedge ACLK);
    check("midrst_idle", 32'(busy), 32'd0);
    push(32'd49, 8'd7, 8'd7, 1'b0);
    do_start(8'd1, 1'b0);
    send(8'd7, 8'd7);
    collect(1'b0);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
